// File: rtl/jk_pd_sequencer.sv
// jk_pd_sequencer
//   Drives the j/k inputs of the JK flip-flop phase detector in the DPLL
//   loop. Reference and DCO-feedback rising edges become one-cycle j/k
//   pulses. j and k are never issued together: a round-robin arbiter
//   resolves conflicts and parks the loser in a one-deep pending flag.
//   The block also measures the detector output duty per reference period,
//   reports a signed phase error and runs the IDLE/ACQ/LOCKED lock FSM.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous, active-high
//   enable     in   1 = run; 0 = FSM to IDLE, j/k held 0
//   ref_in     in   reference clock (async to clk)
//   fb_in      in   DCO feedback clock (async to clk)
//   pd_q       in   phase-detector flop output
//   j, k       out  one-cycle set/reset pulses to the phase-detector flop
//   phase_err  out  signed high_cnt - (period_cnt>>1), CNT_W bits
//   err_valid  out  one-cycle strobe, phase_err updated
//   locked     out  1 while FSM in LOCKED
//   ref_lost   out  sticky; period counter saturated; cleared leaving IDLE
//   overrun    out  one-cycle pulse; event merged into a pending request

// Per-input synchroniser + rising-edge detector.
// STAGES sync flops and one history flop; the edge strobe is registered so
// that a request reaches the j/k flops on the (STAGES+2)th clock edge.
module jk_pd_edge_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic evt
);
  // [STAGES-1:0] synchroniser, [STAGES] history
  logic [STAGES:0] sync_pipe;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_pipe <= '0;
      evt       <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[STAGES-1:0], din};
      evt       <= sync_pipe[STAGES-1] & ~sync_pipe[STAGES];
    end
  end
endmodule

module jk_pd_sequencer #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_TOL    = 4,
  parameter int LOCK_CNT    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             ref_in,
  input  logic             fb_in,
  input  logic             pd_q,
  output logic             j,
  output logic             k,
  output logic [CNT_W-1:0] phase_err,
  output logic             err_valid,
  output logic             locked,
  output logic             ref_lost,
  output logic             overrun
);
  localparam int GOOD_W = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0]        CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]        CNT_MAX   = '1;
  localparam logic signed [CNT_W-1:0] TOL_S     = CNT_W'(LOCK_TOL);
  localparam logic [GOOD_W-1:0]       GOOD_LAST = GOOD_W'(LOCK_CNT - 1);
  localparam logic [GOOD_W-1:0]       GOOD_FULL = GOOD_W'(LOCK_CNT);
  localparam logic [GOOD_W-1:0]       GOOD_ONE  = GOOD_W'(1);

  typedef enum logic [1:0] {S_IDLE, S_ACQ, S_LOCKED} state_t;

  // ---------------------------------------------------------------------
  // Edge detection: lane 0 = reference, lane 1 = feedback
  // ---------------------------------------------------------------------
  logic [1:0] edge_in;
  logic [1:0] evt;
  assign edge_in = {fb_in, ref_in};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_sync
      jk_pd_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
        .clk   (clk),
        .reset (reset),
        .din   (edge_in[g]),
        .evt   (evt[g])
      );
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Round-robin j/k arbiter
  // ---------------------------------------------------------------------
  logic pend_j, pend_k;
  logic last_grant_k;   // 1 = K won the last conflict, so J wins the next one
  logic req_j, req_k, grant_j, grant_k;

  assign req_j   = evt[0] | pend_j;
  assign req_k   = evt[1] | pend_k;
  assign grant_j = req_j & (~req_k | last_grant_k);
  assign grant_k = req_k & ~grant_j;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      j            <= 1'b0;
      k            <= 1'b0;
      pend_j       <= 1'b0;
      pend_k       <= 1'b0;
      overrun      <= 1'b0;
      last_grant_k <= 1'b1;
    end else if (!enable) begin
      j       <= 1'b0;
      k       <= 1'b0;
      pend_j  <= 1'b0;
      pend_k  <= 1'b0;
      overrun <= 1'b0;
    end else begin
      j       <= grant_j;
      k       <= grant_k;
      // The losing request stays parked; a fresh edge on top of it merges.
      pend_j  <= req_j & ~grant_j;
      pend_k  <= req_k & ~grant_k;
      overrun <= (evt[0] & pend_j) | (evt[1] & pend_k);
      // Fairness pointer moves only on a real conflict.
      if (req_j && req_k) last_grant_k <= grant_k;
    end
  end

  // ---------------------------------------------------------------------
  // Lock FSM
  // ---------------------------------------------------------------------
  state_t            state, state_nxt;
  logic [GOOD_W-1:0] good, good_nxt;
  logic              clr_meas, set_lost, clr_lost;
  logic [CNT_W-1:0]  period_cnt, high_cnt;
  logic              period_sat, in_tol;
  logic signed [CNT_W-1:0] pe_s;

  assign period_sat = (period_cnt == CNT_MAX);
  assign pe_s       = phase_err;
  assign in_tol     = (pe_s <= TOL_S) && (pe_s >= -TOL_S);
  assign locked     = (state == S_LOCKED);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
      good  <= '0;
    end else begin
      state <= state_nxt;
      good  <= good_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    good_nxt  = good;
    clr_meas  = 1'b0;
    set_lost  = 1'b0;
    clr_lost  = 1'b0;
    if (!enable) begin
      state_nxt = S_IDLE;
      good_nxt  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          state_nxt = S_ACQ;
          good_nxt  = '0;
          clr_meas  = 1'b1;
          clr_lost  = 1'b1;
        end
        S_ACQ: begin
          if (period_sat) begin
            good_nxt = '0;
            clr_meas = 1'b1;
            set_lost = 1'b1;
          end else if (err_valid) begin
            if (!in_tol) begin
              good_nxt = '0;
            end else if (good == GOOD_LAST) begin
              good_nxt  = GOOD_FULL;
              state_nxt = S_LOCKED;
            end else begin
              good_nxt = good + GOOD_ONE;
            end
          end
        end
        S_LOCKED: begin
          if (period_sat) begin
            state_nxt = S_ACQ;
            good_nxt  = '0;
            clr_meas  = 1'b1;
            set_lost  = 1'b1;
          end else if (err_valid && !in_tol) begin
            state_nxt = S_ACQ;
            good_nxt  = '0;
          end
        end
        default: begin
          state_nxt = S_IDLE;
          good_nxt  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ref_lost <= 1'b0;
    end else if (set_lost) begin
      ref_lost <= 1'b1;
    end else if (clr_lost) begin
      ref_lost <= 1'b0;
    end
  end

  // ---------------------------------------------------------------------
  // Period / high-time measurement
  // ---------------------------------------------------------------------
  logic meas_run;
  logic seen_ref;   // a ref edge has opened the current window

  assign meas_run = enable && (state != S_IDLE) && !clr_meas;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt <= '0;
      high_cnt   <= '0;
      seen_ref   <= 1'b0;
      phase_err  <= '0;
      err_valid  <= 1'b0;
    end else begin
      err_valid <= 1'b0;
      if (!meas_run) begin
        // phase_err deliberately holds across IDLE.
        period_cnt <= '0;
        high_cnt   <= '0;
        seen_ref   <= 1'b0;
      end else if (evt[0]) begin
        if (seen_ref) begin
          phase_err <= high_cnt - (period_cnt >> 1);
          err_valid <= 1'b1;
        end
        seen_ref   <= 1'b1;
        // The edge cycle itself belongs to the new window.
        period_cnt <= CNT_ONE;
        high_cnt   <= pd_q ? CNT_ONE : '0;
      end else begin
        if (!period_sat)               period_cnt <= period_cnt + CNT_ONE;
        if (pd_q && high_cnt != CNT_MAX) high_cnt <= high_cnt + CNT_ONE;
      end
    end
  end
endmodule

// File: tb/tb_jk_pd_sequencer.sv
// Self-checking bench for jk_pd_sequencer (CNT_W = 8 so that saturation is
// reachable quickly). Expected values come from a behavioural model: the
// arbiter as a per-side outstanding-request model, the phase error as
// "pd_q-high cycles in the reference window minus half the window length".
module tb_jk_pd_sequencer;
  localparam int CW  = 8;
  localparam int LAT = 3;    // input change -> edge strobe usable by logic
  localparam int TOL = 4;
  localparam int LCK = 8;

  logic          clk = 1'b0;
  logic          reset, enable, ref_in, fb_in, pd_q;
  logic          j, k, err_valid, locked, ref_lost, overrun;
  logic [CW-1:0] phase_err;

  int n_chk  = 0;
  int n_pass = 0;
  int tick   = 0;

  // measurement stimulus / model state
  bit  rv[2048];
  bit  pdv[2048];
  int  n;
  bit  lk_exp;
  int  lk_cnt;
  logic [CW-1:0] last_err_exp;
  int  last_rise_tick;

  // arbiter stimulus / expectations
  bit ra[400], fa[400], ej[410], ek[410], eo[410];

  always #5 clk = ~clk;

  jk_pd_sequencer #(.CNT_W(CW), .SYNC_STAGES(2), .LOCK_TOL(TOL), .LOCK_CNT(LCK)) dut (
    .clk(clk), .reset(reset), .enable(enable), .ref_in(ref_in), .fb_in(fb_in),
    .pd_q(pd_q), .j(j), .k(k), .phase_err(phase_err), .err_valid(err_valid),
    .locked(locked), .ref_lost(ref_lost), .overrun(overrun));

  task automatic step();
    @(negedge clk);
    tick++;
  endtask

  task automatic apply_reset();
    ref_in = 0; fb_in = 0; pd_q = 0; enable = 0; reset = 1;
    step(); step();
    reset = 0; enable = 1;
    step(); step(); step();
    lk_exp = 0; lk_cnt = 0; n = 0;
  endtask

  task automatic add_period(input int per, input int hi);
    for (int i = 0; i < per; i++) begin
      rv[n] = (i < per / 2); pdv[n] = (i < hi); n++;
    end
  endtask

  task automatic add_tail(input int len);
    for (int i = 0; i < len; i++) begin
      rv[n] = 0; pdv[n] = 0; n++;
    end
  endtask

  // Plays rv/pdv and checks every err_valid and the lock flag every cycle.
  task automatic run_meas(input string tag);
    int rises[$];
    logic [CW-1:0] errq[$];
    logic [CW-1:0] e;
    bit prev;
    prev = 0;
    for (int t = 0; t < n; t++) begin
      if (rv[t] && !prev) rises.push_back(t);
      prev = rv[t];
    end
    for (int i = 1; i < rises.size(); i++) begin
      int hi, d;
      hi = 0;
      for (int t = rises[i-1] + LAT; t < rises[i] + LAT; t++) if (t < n) hi += pdv[t];
      d = hi - ((rises[i] - rises[i-1]) / 2);
      errq.push_back(CW'(d));
    end
    prev = 0;
    for (int s = 0; s < n; s++) begin
      step();
      n_chk++;
      if (locked !== lk_exp) $display("FAIL %s_locked t=%0d: got %b want %b", tag, s, locked, lk_exp);
      else n_pass++;
      if (err_valid === 1'b1) begin
        n_chk++;
        if (errq.size() == 0) $display("FAIL %s_extra_err_valid t=%0d: got err_valid 1 want 0", tag, s);
        else begin
          e = errq.pop_front();
          if (phase_err !== e) $display("FAIL %s_phase_err t=%0d: got %0d want %0d", tag, s, $signed(phase_err), $signed(e));
          else n_pass++;
          last_err_exp = e;
          if ($signed(e) <= TOL && $signed(e) >= -TOL) begin
            lk_cnt++;
            if (lk_cnt >= LCK) lk_exp = 1;
          end else begin
            lk_cnt = 0; lk_exp = 0;
          end
        end
      end
      if (rv[s] && !prev) last_rise_tick = tick;
      prev = rv[s];
      ref_in = rv[s]; pd_q = pdv[s];
    end
    pd_q = 0;
    n_chk++;
    if (errq.size() != 0) $display("FAIL %s_missing_err_valid: got %0d left want 0", tag, errq.size());
    else n_pass++;
  endtask

  task automatic test_reset();
    reset = 1; enable = 0; ref_in = 0; fb_in = 0; pd_q = 0;
    step(); step();
    n_chk += 7;
    if (j !== 0)         $display("FAIL reset_j: got %b want 0", j); else n_pass++;
    if (k !== 0)         $display("FAIL reset_k: got %b want 0", k); else n_pass++;
    if (err_valid !== 0) $display("FAIL reset_err_valid: got %b want 0", err_valid); else n_pass++;
    if (locked !== 0)    $display("FAIL reset_locked: got %b want 0", locked); else n_pass++;
    if (ref_lost !== 0)  $display("FAIL reset_ref_lost: got %b want 0", ref_lost); else n_pass++;
    if (overrun !== 0)   $display("FAIL reset_overrun: got %b want 0", overrun); else n_pass++;
    if (phase_err !== 0) $display("FAIL reset_phase_err: got %0d want 0", phase_err); else n_pass++;
  endtask

  task automatic test_latency();
    apply_reset();
    ref_in = 1;
    for (int i = 1; i <= 6; i++) begin
      step();
      n_chk += 2;
      if (j !== (i == 4)) $display("FAIL latency_j edge%0d: got %b want %b", i, j, (i == 4)); else n_pass++;
      if (k !== 0)        $display("FAIL latency_k edge%0d: got %b want 0", i, k); else n_pass++;
    end
    ref_in = 0;
    step(); step();
  endtask

  task automatic test_conflict();
    bit wj[7], wk[7];
    apply_reset();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 7; i++) begin
        wj[i] = (r == 0) ? (i == 4) : (i == 5);
        wk[i] = (r == 0) ? (i == 5) : (i == 4);
      end
      ref_in = 1; fb_in = 1;
      for (int i = 1; i <= 6; i++) begin
        step();
        if (i == 2) begin ref_in = 0; fb_in = 0; end
        n_chk += 3;
        if (j !== wj[i]) $display("FAIL conflict%0d_j edge%0d: got %b want %b", r, i, j, wj[i]); else n_pass++;
        if (k !== wk[i]) $display("FAIL conflict%0d_k edge%0d: got %b want %b", r, i, k, wk[i]); else n_pass++;
        if ((j & k) !== 0) $display("FAIL conflict%0d_jk_both edge%0d: got 1 want 0", r, i); else n_pass++;
      end
      step(); step();
    end
  endtask

  task automatic test_random_arbiter();
    bit pj, pk, k_turn, er, ef, rj, rk, gj, gk;
    apply_reset();
    for (int t = 0; t < 300; t++) begin
      ra[t] = (t == 0) ? ($urandom_range(0, 2) == 0) : (($urandom_range(0, 2) == 0) ? ~ra[t-1] : ra[t-1]);
      fa[t] = (t == 0) ? ($urandom_range(0, 2) == 0) : (($urandom_range(0, 2) == 0) ? ~fa[t-1] : fa[t-1]);
    end
    for (int t = 0; t < 410; t++) begin ej[t] = 0; ek[t] = 0; eo[t] = 0; end
    // one outstanding request per side; a contested cycle goes to whichever
    // side did not take the previous contested cycle (J first after reset)
    pj = 0; pk = 0; k_turn = 0;
    for (int d = 0; d < 305; d++) begin
      er = (d >= LAT && d - LAT < 300) && ra[d-LAT] && !((d - LAT > 0) ? ra[d-LAT-1] : 1'b0);
      ef = (d >= LAT && d - LAT < 300) && fa[d-LAT] && !((d - LAT > 0) ? fa[d-LAT-1] : 1'b0);
      eo[d+1] = (er && pj) || (ef && pk);
      rj = er || pj; rk = ef || pk;
      if (rj && rk) begin
        gj = !k_turn; gk = k_turn; k_turn = !k_turn;
      end else begin
        gj = rj; gk = rk;
      end
      ej[d+1] = gj; ek[d+1] = gk;
      pj = rj && !gj; pk = rk && !gk;
    end
    for (int s = 0; s < 306; s++) begin
      step();
      n_chk += 3;
      if (j !== ej[s]) $display("FAIL rand_arb_j t=%0d: got %b want %b", s, j, ej[s]); else n_pass++;
      if (k !== ek[s]) $display("FAIL rand_arb_k t=%0d: got %b want %b", s, k, ek[s]); else n_pass++;
      if (overrun !== eo[s]) $display("FAIL rand_arb_overrun t=%0d: got %b want %b", s, overrun, eo[s]); else n_pass++;
      ref_in = (s < 300) ? ra[s] : 1'b0;
      fb_in  = (s < 300) ? fa[s] : 1'b0;
    end
  endtask

  task automatic test_lock();
    apply_reset();
    for (int p = 0; p < 10; p++) add_period(100, 52);
    for (int p = 0; p < 3; p++)  add_period(100, 60);
    add_tail(10);
    run_meas("lock");
  endtask

  task automatic test_random_meas();
    int per;
    apply_reset();
    for (int p = 0; p < 14; p++) begin
      per = $urandom_range(40, 120);
      add_period(per, per / 2 + $urandom_range(0, 8) - 4);
    end
    add_tail(10);
    run_meas("rmeas");
  endtask

  task automatic test_ref_lost_and_disable();
    int target;
    apply_reset();
    for (int p = 0; p < 10; p++) add_period(100, 52);
    add_tail(10);
    run_meas("lost_pre");
    n_chk++;
    if (locked !== 1) $display("FAIL lost_pre_locked: got %b want 1", locked); else n_pass++;
    target = last_rise_tick + LAT + 256;   // 255-cycle window, then flag edge
    while (tick < target - 1) step();
    n_chk += 2;
    if (ref_lost !== 0) $display("FAIL ref_lost_early: got %b want 0", ref_lost); else n_pass++;
    if (locked !== 1)   $display("FAIL locked_before_sat: got %b want 1", locked); else n_pass++;
    step();
    n_chk += 2;
    if (ref_lost !== 1) $display("FAIL ref_lost_set: got %b want 1", ref_lost); else n_pass++;
    if (locked !== 0)   $display("FAIL locked_after_sat: got %b want 0", locked); else n_pass++;
    step(); step();
    enable = 0;
    step(); step();
    n_chk += 6;
    if (locked !== 0)    $display("FAIL idle_locked: got %b want 0", locked); else n_pass++;
    if (ref_lost !== 1)  $display("FAIL idle_ref_lost_sticky: got %b want 1", ref_lost); else n_pass++;
    if (phase_err !== last_err_exp) $display("FAIL idle_phase_err_hold: got %0d want %0d", phase_err, last_err_exp); else n_pass++;
    if (err_valid !== 0) $display("FAIL idle_err_valid: got %b want 0", err_valid); else n_pass++;
    if (j !== 0)         $display("FAIL idle_j: got %b want 0", j); else n_pass++;
    if (k !== 0)         $display("FAIL idle_k: got %b want 0", k); else n_pass++;
    enable = 1;
    step(); step();
    n_chk++;
    if (ref_lost !== 0) $display("FAIL ref_lost_clear: got %b want 0", ref_lost); else n_pass++;
  endtask

  task automatic test_reset_mid_pulse();
    apply_reset();
    ref_in = 1;
    step(); step(); step(); step();
    n_chk++;
    if (j !== 1) $display("FAIL midpulse_j_before: got %b want 1", j); else n_pass++;
    reset = 1;
    #1;
    n_chk += 2;
    if (j !== 0) $display("FAIL midpulse_j_reset: got %b want 0", j); else n_pass++;
    if (k !== 0) $display("FAIL midpulse_k_reset: got %b want 0", k); else n_pass++;
    step();
    reset = 0; ref_in = 0;
    step(); step();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_conflict();
    test_random_arbiter();
    test_lock();
    test_random_meas();
    test_ref_lost_and_disable();
    test_reset_mid_pulse();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
